sal_dfi_mem_responder: RTL

- PHY/DRAM-side responder for the controller's DFI control, write-data and read-data interfaces; the DFI sink for everything the controller sources.
- Decodes DDR commands, tracks per-bank open/closed state and row, and captures write bursts into a small aliased storage array.
- Returns read bursts at a fixed latency and flags protocol violations.
- Used as the memory end in controller simulation benches and as an FPGA loopback target.

---
 rtl/sal_dfi_mem_responder.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/sal_dfi_mem_responder.sv
// sal_dfi_mem_responder
// DRAM/PHY-side DFI responder. It decodes DDR commands and tracks each bank's
// open/closed state and row. Write bursts are captured into a small aliased
// storage array. Read bursts are returned at a fixed latency. Protocol
// violations raise a sticky error.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   dfi_cs_n/ras_n/cas_n/we_n, dfi_bank, dfi_address
//                       DFI command bus (A10 selects all-bank precharge)
//   dfi_wrdata_en, dfi_wrdata, dfi_wrdata_mask
//                       write beats (mask bit 1 = byte not written)
//   dfi_rddata_valid, dfi_rddata
//                       read beats, registered, zero when not valid
//   err_o, err_code_o   sticky error flag and code of the first error
//                       (1 ACT to open bank, 2 RD/WR to closed bank,
//                        3 REF with open bank, 4 write-data timing,
//                        5 burst spacing)
module sal_dfi_mem_responder #(
  parameter int unsigned BA_W   = 3,
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned BEATS  = 4,
  parameter int unsigned WR_LAT = 2,
  parameter int unsigned RD_LAT = 4,
  parameter int unsigned MEM_AW = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                dfi_cs_n,
  input  logic                dfi_ras_n,
  input  logic                dfi_cas_n,
  input  logic                dfi_we_n,
  input  logic [BA_W-1:0]     dfi_bank,
  input  logic [ADDR_W-1:0]   dfi_address,
  input  logic                dfi_wrdata_en,
  input  logic [DATA_W-1:0]   dfi_wrdata,
  input  logic [DATA_W/8-1:0] dfi_wrdata_mask,
  output logic                dfi_rddata_valid,
  output logic [DATA_W-1:0]   dfi_rddata,
  output logic                err_o,
  output logic [2:0]          err_code_o
);

  localparam int unsigned NBANK  = 1 << BA_W;
  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned BEAT_W = $clog2(BEATS);
  localparam int unsigned COL_LO = BEAT_W + 1;
  localparam int unsigned SLOT_W = MEM_AW + BEAT_W;
  localparam int unsigned DEPTH  = 1 << SLOT_W;
  localparam int unsigned NENT   = 1 << MEM_AW;
  localparam int unsigned RD_D   = RD_LAT - 1;
  localparam int unsigned WR_D   = WR_LAT;
  localparam int unsigned LANES  = DATA_W / 32;
  localparam int unsigned GAP_W  = $clog2(BEATS + 1);
  localparam logic [31:0] POISON = 32'hDEADBEEF;

  // Command decode
  logic cmd_act, cmd_rd, cmd_wr, cmd_pre, cmd_ref;

  always_comb begin
    cmd_act = 1'b0;
    cmd_rd  = 1'b0;
    cmd_wr  = 1'b0;
    cmd_pre = 1'b0;
    cmd_ref = 1'b0;
    if (!dfi_cs_n) begin
      case ({dfi_ras_n, dfi_cas_n, dfi_we_n})
        3'b011:  cmd_act = 1'b1;
        3'b101:  cmd_rd  = 1'b1;
        3'b100:  cmd_wr  = 1'b1;
        3'b010:  cmd_pre = 1'b1;
        3'b001:  cmd_ref = 1'b1;
        default: ;
      endcase
    end
  end

  // Bank state and storage index of the addressed column
  logic [NBANK-1:0]  bank_open;
  logic [ADDR_W-1:0] bank_row [NBANK];
  logic              sel_open;
  logic [MEM_AW-1:0] cmd_idx;

  assign sel_open = bank_open[dfi_bank];
  assign cmd_idx  = MEM_AW'({bank_row[dfi_bank], dfi_bank, dfi_address[9:COL_LO]});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_open <= '0;
      for (int i = 0; i < int'(NBANK); i++) bank_row[i] <= '0;
    end else if (cmd_act && !sel_open) begin
      bank_open[dfi_bank] <= 1'b1;
      bank_row[dfi_bank]  <= dfi_address;
    end else if (cmd_pre) begin
      if (dfi_address[10]) bank_open <= '0;
      else                 bank_open[dfi_bank] <= 1'b0;
    end
  end

  // Same-direction burst spacing: cycles since the last accepted command, saturating
  logic [GAP_W-1:0] rd_gap, wr_gap;
  logic             rd_gap_ok, wr_gap_ok, rd_accept, wr_accept;

  assign rd_gap_ok = (rd_gap >= GAP_W'(BEATS));
  assign wr_gap_ok = (wr_gap >= GAP_W'(BEATS));
  assign rd_accept = cmd_rd && sel_open && rd_gap_ok;
  assign wr_accept = cmd_wr && sel_open && wr_gap_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_gap <= GAP_W'(BEATS);
      wr_gap <= GAP_W'(BEATS);
    end else begin
      if (rd_accept)       rd_gap <= GAP_W'(1);
      else if (!rd_gap_ok) rd_gap <= rd_gap + GAP_W'(1);
      if (wr_accept)       wr_gap <= GAP_W'(1);
      else if (!wr_gap_ok) wr_gap <= wr_gap + GAP_W'(1);
    end
  end

  // Read delay line; the tail holds a command issued RD_LAT-1 cycles ago so beat 0
  // is fetched one cycle early into the output register.
  logic [RD_D-1:0]   rd_pv;
  logic [MEM_AW-1:0] rd_pi [RD_D];
  logic [WR_D-1:0]   wr_pv;
  logic [MEM_AW-1:0] wr_pi [WR_D];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_pv <= '0;
      wr_pv <= '0;
      for (int i = 0; i < int'(RD_D); i++) rd_pi[i] <= '0;
      for (int i = 0; i < int'(WR_D); i++) wr_pi[i] <= '0;
    end else begin
      rd_pv[0] <= rd_accept;
      rd_pi[0] <= cmd_idx;
      for (int i = 1; i < int'(RD_D); i++) begin
        rd_pv[i] <= rd_pv[i-1];
        rd_pi[i] <= rd_pi[i-1];
      end
      wr_pv[0] <= wr_accept;
      wr_pi[0] <= cmd_idx;
      for (int i = 1; i < int'(WR_D); i++) begin
        wr_pv[i] <= wr_pv[i-1];
        wr_pi[i] <= wr_pi[i-1];
      end
    end
  end

  // Beat counters: the delay-line tail starts beat 0, the counter covers the rest
  logic              rd_act, wr_act;
  logic [BEAT_W-1:0] rd_cnt, wr_cnt;
  logic [MEM_AW-1:0] rd_bidx, wr_bidx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_act  <= 1'b0;
      rd_cnt  <= '0;
      rd_bidx <= '0;
      wr_act  <= 1'b0;
      wr_cnt  <= '0;
      wr_bidx <= '0;
    end else begin
      if (rd_act) begin
        rd_cnt <= rd_cnt + BEAT_W'(1);
        if (rd_cnt == BEAT_W'(BEATS - 1)) rd_act <= 1'b0;
      end else if (rd_pv[RD_D-1]) begin
        rd_act  <= 1'b1;
        rd_cnt  <= BEAT_W'(1);
        rd_bidx <= rd_pi[RD_D-1];
      end
      if (wr_act) begin
        wr_cnt <= wr_cnt + BEAT_W'(1);
        if (wr_cnt == BEAT_W'(BEATS - 1)) wr_act <= 1'b0;
      end else if (wr_pv[WR_D-1]) begin
        wr_act  <= 1'b1;
        wr_cnt  <= BEAT_W'(1);
        wr_bidx <= wr_pi[WR_D-1];
      end
    end
  end

  // Current write window and read fetch slot
  logic              wr_win, wr_fire, rd_launch;
  logic [MEM_AW-1:0] wr_eidx, rd_eidx;
  logic [SLOT_W-1:0] wr_slot, rd_slot;

  assign wr_win    = wr_pv[WR_D-1] | wr_act;
  assign wr_fire   = wr_win && dfi_wrdata_en;
  assign wr_eidx   = wr_act ? wr_bidx : wr_pi[WR_D-1];
  assign wr_slot   = {wr_eidx, (wr_act ? wr_cnt : BEAT_W'(0))};
  assign rd_launch = rd_pv[RD_D-1] | rd_act;
  assign rd_eidx   = rd_act ? rd_bidx : rd_pi[RD_D-1];
  assign rd_slot   = {rd_eidx, (rd_act ? rd_cnt : BEAT_W'(0))};

  // Storage array (contents survive reset) and per-entry written bits
  logic [DATA_W-1:0] mem [DEPTH];
  logic [NENT-1:0]   written;

  always_ff @(posedge clk) begin
    if (rst_n && wr_fire) begin
      for (int b = 0; b < int'(MASK_W); b++) begin
        if (!dfi_wrdata_mask[b]) mem[wr_slot][8*b +: 8] <= dfi_wrdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)       written <= '0;
    else if (wr_fire) written[wr_eidx] <= 1'b1;
  end

  // Fetched beat includes a write committing at the same edge, so the beat shows
  // array contents as of the cycle it is presented in.
  logic [DATA_W-1:0] rd_fwd, rd_beat;
  logic              rd_written;

  always_comb begin
    rd_fwd = mem[rd_slot];
    if (wr_fire && (wr_slot == rd_slot)) begin
      for (int b = 0; b < int'(MASK_W); b++) begin
        if (!dfi_wrdata_mask[b]) rd_fwd[8*b +: 8] = dfi_wrdata[8*b +: 8];
      end
    end
    rd_written = written[rd_eidx] | (wr_fire && (wr_eidx == rd_eidx));
    rd_beat    = rd_written ? rd_fwd : {LANES{POISON}};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dfi_rddata_valid <= 1'b0;
      dfi_rddata       <= '0;
    end else begin
      dfi_rddata_valid <= rd_launch;
      dfi_rddata       <= rd_launch ? rd_beat : '0;
    end
  end

  // Error detection; bit i flags code i+1, lowest code wins
  logic [4:0] err_vec;
  logic [2:0] err_next;

  always_comb begin
    err_vec    = '0;
    err_vec[0] = cmd_act && sel_open;
    err_vec[1] = (cmd_rd || cmd_wr) && !sel_open;
    err_vec[2] = cmd_ref && (|bank_open);
    err_vec[3] = wr_win ^ dfi_wrdata_en;
    err_vec[4] = (cmd_rd && sel_open && !rd_gap_ok) || (cmd_wr && sel_open && !wr_gap_ok);
    err_next   = '0;
    for (int i = 4; i >= 0; i--) begin
      if (err_vec[i]) err_next = 3'(i + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_o      <= 1'b0;
      err_code_o <= '0;
    end else if (!err_o && (|err_vec)) begin
      err_o      <= 1'b1;
      err_code_o <= err_next;
    end
  end

endmodule
